// File: rtl/sw_debounce.sv
// Slide-switch conditioner: two-flop synchroniser, per-bit debounce counter,
// registered clean levels with rise/fall/changed strobes.
module sw_debounce #(
    parameter int WIDTH         = 8,
    parameter int STABLE_CYCLES = 100000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw,
    output logic [WIDTH-1:0] sw_o,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);

    localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] sw_q, sw_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic             changed_q, changed_d;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];

    // A bit is qualifying whenever its synchronised level differs from the
    // clean level; any return to the clean level restarts the count.
    always_comb begin
        sw_d   = sw_q;
        rise_d = '0;
        fall_d = '0;
        cnt_d  = cnt_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (sync2_q[i] != sw_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    sw_d[i]   = sync2_q[i];
                    rise_d[i] = sync2_q[i];
                    fall_d[i] = ~sync2_q[i];
                    cnt_d[i]  = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end else begin
                cnt_d[i] = '0;
            end
        end
        changed_d = |(rise_d | fall_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            sw_q      <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= sw;
            sync2_q   <= sync1_q;
            sw_q      <= sw_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= changed_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign sw_o    = sw_q;
    assign rise    = rise_q;
    assign fall    = fall_q;
    assign changed = changed_q;

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with STABLE_CYCLES=4; checks the packed
// {sw_o, rise, fall, changed} after every edge against hand-derived values.
module tb_sw_debounce;

    logic       clk;
    logic       rst;
    logic [7:0] sw;
    logic [7:0] sw_o, rise, fall;
    logic       changed;

    int total = 0;
    int bad   = 0;
    logic [24:0] obs, exp;

    sw_debounce #(.WIDTH(8), .STABLE_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .sw(sw),
        .sw_o(sw_o), .rise(rise), .fall(fall), .changed(changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        sw  = 8'hFF;
        rst = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            obs = {sw_o, rise, fall, changed};
            exp = 25'h0;
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL reset_hold k=%0d got=%h want=%h", k, obs, exp);
            end
        end
        sw  = 8'h00;
        rst = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            obs = {sw_o, rise, fall, changed};
            exp = 25'h0;
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL reset_release k=%0d got=%h want=%h", k, obs, exp);
            end
        end
    endtask

    task automatic test_clean_edge();
        sw = 8'h10;
        for (int k = 1; k <= 8; k++) begin
            tick();
            obs = {sw_o, rise, fall, changed};
            exp = {(k >= 6) ? 8'h10 : 8'h00, (k == 6) ? 8'h10 : 8'h00, 8'h00, k == 6};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL clean_rise k=%0d got=%h want=%h", k, obs, exp);
            end
        end
    endtask

    task automatic test_clean_fall();
        sw = 8'h00;
        for (int k = 1; k <= 8; k++) begin
            tick();
            obs = {sw_o, rise, fall, changed};
            exp = {(k >= 6) ? 8'h00 : 8'h10, 8'h00, (k == 6) ? 8'h10 : 8'h00, k == 6};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL clean_fall k=%0d got=%h want=%h", k, obs, exp);
            end
        end
    endtask

    task automatic test_bounce_reject();
        logic [4:0] pat;
        pat = 5'b01101;
        for (int k = 0; k < 13; k++) begin
            sw = (k < 5) ? {7'h00, pat[k]} : 8'h00;
            tick();
            obs = {sw_o, rise, fall, changed};
            exp = 25'h0;
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL bounce_reject k=%0d got=%h want=%h", k, obs, exp);
            end
        end
    endtask

    task automatic test_bounce_settle();
        logic [2:0] pat;
        pat = 3'b001;
        for (int k = 0; k < 3; k++) begin
            sw = {pat[k], 7'h00};
            tick();
            obs = {sw_o, rise, fall, changed};
            exp = 25'h0;
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL bounce_phase k=%0d got=%h want=%h", k, obs, exp);
            end
        end
        sw = 8'h80;
        for (int k = 1; k <= 8; k++) begin
            tick();
            obs = {sw_o, rise, fall, changed};
            exp = {(k >= 6) ? 8'h80 : 8'h00, (k == 6) ? 8'h80 : 8'h00, 8'h00, k == 6};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL bounce_settle k=%0d got=%h want=%h", k, obs, exp);
            end
        end
    endtask

    task automatic test_simultaneous();
        sw = 8'h0F;
        for (int k = 1; k <= 8; k++) begin
            tick();
            obs = {sw_o, rise, fall, changed};
            exp = {(k >= 6) ? 8'h0F : 8'h80, (k == 6) ? 8'h0F : 8'h00,
                   (k == 6) ? 8'h80 : 8'h00, k == 6};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL multi_setup k=%0d got=%h want=%h", k, obs, exp);
            end
        end
        sw = 8'hF0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            obs = {sw_o, rise, fall, changed};
            exp = {(k >= 6) ? 8'hF0 : 8'h0F, (k == 6) ? 8'hF0 : 8'h00,
                   (k == 6) ? 8'h0F : 8'h00, k == 6};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL simultaneous k=%0d got=%h want=%h", k, obs, exp);
            end
        end
    endtask

    task automatic test_reset_mid_qual();
        sw  = 8'h00;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        tick();
        obs = {sw_o, rise, fall, changed};
        exp = 25'h0;
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL midq_clear got=%h want=%h", obs, exp);
        end
        sw = 8'h01;
        for (int k = 1; k <= 3; k++) begin
            tick();
            obs = {sw_o, rise, fall, changed};
            exp = 25'h0;
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL midq_pre k=%0d got=%h want=%h", k, obs, exp);
            end
        end
        rst = 1'b1;
        tick();
        obs = {sw_o, rise, fall, changed};
        exp = 25'h0;
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL midq_rst got=%h want=%h", obs, exp);
        end
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            obs = {sw_o, rise, fall, changed};
            exp = {(k >= 6) ? 8'h01 : 8'h00, (k == 6) ? 8'h01 : 8'h00, 8'h00, k == 6};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL midq_requal k=%0d got=%h want=%h", k, obs, exp);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        sw  = 8'h00;
        test_reset();
        test_clean_edge();
        test_clean_fall();
        test_bounce_reject();
        test_bounce_settle();
        test_simultaneous();
        test_reset_mid_qual();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
